// File: rtl/uart_rx_display_driver_pkg.sv
// Shared constants for the UART receive display driver.
// Covers the segment patterns, the scan-state encoding and the default refresh divider.
package uart_rx_display_driver_pkg;

    localparam int REFRESH_DIV_DEFAULT = 16;

    // Scan states. The state number is the index of the digit being lit.
    localparam logic [1:0] DIG0 = 2'd0;
    localparam logic [1:0] DIG1 = 2'd1;
    localparam logic [1:0] DIG2 = 2'd2;
    localparam logic [1:0] DIG3 = 2'd3;

    // Active-low segment patterns, bit order {a,b,c,d,e,f,g}.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_P     = 7'b0011000;
    localparam logic [6:0] SEG_F     = 7'b0111000;

    typedef enum logic {
        ERR_P = 1'b0,
        ERR_F = 1'b1
    } err_kind_t;

    // Active-low one-hot anode enable for a scan state.
    function automatic logic [3:0] anode_for(input logic [1:0] dig);
        return ~(4'b0001 << dig);
    endfunction

endpackage

// File: rtl/uart_rx_display_driver_hex_to_7seg.sv
// Combinational decoder from a hex nibble to an active-low 7-segment pattern {a..g}.
module hex_to_7seg
    import uart_rx_display_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Nibble to segment lookup; lowercase b and d keep them distinct from 8 and 0.
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/uart_rx_display_driver.sv
// Shows the last two bytes from the UART receiver on a 4-digit common-anode display.
// A parity or framing error is held as "E P/F - -" until the next good byte arrives.
//
// state | meaning
// DIG0  | rightmost digit lit: low nibble of the newest byte
// DIG1  | high nibble of the newest byte
// DIG2  | low nibble of the previous byte, or P/F when in error
// DIG3  | high nibble of the previous byte, or E when in error
//
// Reset parks the FSM in DIG3 with the anodes off, so the first tick lights DIG0.
module uart_rx_display_driver
    import uart_rx_display_driver_pkg::*;
#(
    parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic [7:0] Rx_DATA,
    input  logic       Rx_VALID,
    input  logic       Rx_PERROR,
    input  logic       Rx_FERROR,
    output logic [3:0] An,
    output logic [6:0] Seg,
    output logic       Disp_Error
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] refresh_cnt;
    logic             tick;

    logic             valid_q, perror_q, ferror_q;
    logic             valid_rise, perror_rise, ferror_rise, err_rise;

    logic [7:0]       lo_byte, hi_byte;
    logic [1:0]       byte_cnt;
    logic             err;
    err_kind_t        err_kind;

    logic [1:0]       state, next_state;
    logic [3:0]       digit_nibble;
    logic             digit_special;
    logic [6:0]       special_seg;
    logic [6:0]       hex_seg;
    logic [6:0]       seg_next;

    assign tick        = (refresh_cnt == CNT_LAST);
    assign valid_rise  = Rx_VALID  & ~valid_q;
    assign perror_rise = Rx_PERROR & ~perror_q;
    assign ferror_rise = Rx_FERROR & ~ferror_q;
    assign err_rise    = perror_rise | ferror_rise;
    assign next_state  = state + 2'd1;
    assign Disp_Error  = err;

    // Free-running refresh counter; the last count is the digit-advance tick.
    always_ff @(posedge Clk) begin
        if (reset) begin
            refresh_cnt <= '0;
        end else if (tick) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Previous-cycle copies of the receiver flags, so a held level yields one event.
    always_ff @(posedge Clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            perror_q <= 1'b0;
            ferror_q <= 1'b0;
        end else begin
            valid_q  <= Rx_VALID;
            perror_q <= Rx_PERROR;
            ferror_q <= Rx_FERROR;
        end
    end

    // Byte history and error latch. An error in the same cycle as a valid byte drops the byte.
    always_ff @(posedge Clk) begin
        if (reset) begin
            lo_byte  <= 8'h00;
            hi_byte  <= 8'h00;
            byte_cnt <= 2'd0;
            err      <= 1'b0;
            err_kind <= ERR_P;
        end else if (err_rise) begin
            err      <= 1'b1;
            err_kind <= ferror_rise ? ERR_F : ERR_P;
        end else if (valid_rise) begin
            lo_byte <= Rx_DATA;
            err     <= 1'b0;
            if (err) begin
                // The byte before an error is stale, so history restarts at one byte.
                byte_cnt <= 2'd1;
            end else begin
                hi_byte <= lo_byte;
                if (byte_cnt != 2'd2) begin
                    byte_cnt <= byte_cnt + 2'd1;
                end
            end
        end
    end

    // Digit content for the slot about to be lit.
    always_comb begin
        digit_nibble  = 4'h0;
        digit_special = 1'b1;
        special_seg   = SEG_BLANK;
        if (err) begin
            case (next_state)
                DIG3:    special_seg = SEG_E;
                DIG2:    special_seg = (err_kind == ERR_F) ? SEG_F : SEG_P;
                default: special_seg = SEG_DASH;
            endcase
        end else begin
            case (next_state)
                DIG0: if (byte_cnt != 2'd0) begin
                    digit_special = 1'b0;
                    digit_nibble  = lo_byte[3:0];
                end
                DIG1: if (byte_cnt != 2'd0) begin
                    digit_special = 1'b0;
                    digit_nibble  = lo_byte[7:4];
                end
                DIG2: if (byte_cnt == 2'd2) begin
                    digit_special = 1'b0;
                    digit_nibble  = hi_byte[3:0];
                end
                default: if (byte_cnt == 2'd2) begin
                    digit_special = 1'b0;
                    digit_nibble  = hi_byte[7:4];
                end
            endcase
        end
    end

    hex_to_7seg u_hex_to_7seg (
        .nibble (digit_nibble),
        .seg    (hex_seg)
    );

    assign seg_next = digit_special ? special_seg : hex_seg;

    // Scan FSM: on each tick move to the next digit and register its anode and segments together.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state <= DIG3;
            An    <= 4'b1111;
            Seg   <= SEG_BLANK;
        end else if (tick) begin
            state <= next_state;
            An    <= anode_for(next_state);
            Seg   <= seg_next;
        end
    end

endmodule

// File: tb/tb_uart_rx_display_driver.sv
// Directed bench for uart_rx_display_driver with a 4-cycle refresh divider.
module tb_uart_rx_display_driver;

    logic       Clk = 1'b0;
    logic       reset;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;
    logic [3:0] An;
    logic [6:0] Seg;
    logic       Disp_Error;

    int tests  = 0;
    int failed = 0;

    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_DASH  = 7'b1111110;
    localparam logic [6:0] S_0 = 7'b0000001;
    localparam logic [6:0] S_1 = 7'b1001111;
    localparam logic [6:0] S_2 = 7'b0010010;
    localparam logic [6:0] S_3 = 7'b0000110;
    localparam logic [6:0] S_4 = 7'b1001100;
    localparam logic [6:0] S_5 = 7'b0100100;
    localparam logic [6:0] S_8 = 7'b0000000;
    localparam logic [6:0] S_A = 7'b0001000;
    localparam logic [6:0] S_C = 7'b0110001;
    localparam logic [6:0] S_E = 7'b0110000;
    localparam logic [6:0] S_F = 7'b0111000;
    localparam logic [6:0] S_P = 7'b0011000;

    uart_rx_display_driver #(.REFRESH_DIV(4)) dut (
        .Clk        (Clk),
        .reset      (reset),
        .Rx_DATA    (Rx_DATA),
        .Rx_VALID   (Rx_VALID),
        .Rx_PERROR  (Rx_PERROR),
        .Rx_FERROR  (Rx_FERROR),
        .An         (An),
        .Seg        (Seg),
        .Disp_Error (Disp_Error)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Waits for a fresh entry into digit idx, then checks its segments.
    task automatic chk_digit(input string tag, input int idx, input logic [6:0] exp);
        logic [3:0] pat;
        int n;
        bit ok;
        pat = ~(4'b0001 << idx);
        n = 0;
        while (An === pat && n < 40) begin step(); n++; end
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (An === pat) begin ok = 1'b1; break; end
            step();
        end
        if (!ok) begin
            tests++;
            failed++;
            $error("FAIL %s: digit %0d never lit, An observed %b expected %b", tag, idx, An, pat);
        end else begin
            chk(tag, Seg, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input int hold);
        Rx_DATA  = d;
        Rx_VALID = 1'b1;
        repeat (hold) step();
        Rx_VALID = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; Rx_DATA = 8'h00; Rx_VALID = 1'b0; Rx_PERROR = 1'b0; Rx_FERROR = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        chk("rst_an", {3'b0, An}, 7'b0001111);
        chk("rst_seg", Seg, S_BLANK);
        chk("rst_err", {6'b0, Disp_Error}, 7'd0);

        repeat (3) step();
        chk("idle_an_before_tick", {3'b0, An}, 7'b0001111);
        step();
        chk("idle_an_dig0", {3'b0, An}, 7'b0001110);
        chk("idle_seg_dig0", Seg, S_BLANK);
        repeat (4) step();
        chk("idle_an_dig1", {3'b0, An}, 7'b0001101);
        chk("idle_seg_dig1", Seg, S_BLANK);
        repeat (4) step();
        chk("idle_an_dig2", {3'b0, An}, 7'b0001011);
        chk("idle_seg_dig2", Seg, S_BLANK);
        repeat (4) step();
        chk("idle_an_dig3", {3'b0, An}, 7'b0000111);
        chk("idle_seg_dig3", Seg, S_BLANK);

        send_byte(8'hA5, 10);
        chk_digit("a5_d0", 0, S_5);
        chk_digit("a5_d1", 1, S_A);
        chk_digit("a5_d2_blank", 2, S_BLANK);
        chk_digit("a5_d3_blank", 3, S_BLANK);
        chk("a5_err", {6'b0, Disp_Error}, 7'd0);

        send_byte(8'h3C, 2);
        chk_digit("3c_d0", 0, S_C);
        chk_digit("3c_d1", 1, S_3);
        chk_digit("3c_d2", 2, S_5);
        chk_digit("3c_d3", 3, S_A);

        send_byte(8'h0F, 1);
        chk_digit("0f_d0", 0, S_F);
        chk_digit("0f_d1", 1, S_0);
        chk_digit("0f_d2", 2, S_C);
        chk_digit("0f_d3", 3, S_3);

        Rx_PERROR = 1'b1;
        step();
        chk("perr_disp_error", {6'b0, Disp_Error}, 7'd1);
        step();
        Rx_PERROR = 1'b0;
        chk_digit("perr_d3", 3, S_E);
        chk_digit("perr_d2", 2, S_P);
        chk_digit("perr_d1", 1, S_DASH);
        chk_digit("perr_d0", 0, S_DASH);

        send_byte(8'h81, 3);
        chk("81_disp_error", {6'b0, Disp_Error}, 7'd0);
        chk_digit("81_d0", 0, S_1);
        chk_digit("81_d1", 1, S_8);
        chk_digit("81_d2_blank", 2, S_BLANK);
        chk_digit("81_d3_blank", 3, S_BLANK);

        Rx_PERROR = 1'b1; Rx_FERROR = 1'b1;
        step();
        chk("pf_disp_error", {6'b0, Disp_Error}, 7'd1);
        Rx_PERROR = 1'b0; Rx_FERROR = 1'b0;
        chk_digit("pf_d2_f_wins", 2, S_F);
        chk_digit("pf_d3", 3, S_E);

        Rx_FERROR = 1'b1; Rx_VALID = 1'b1; Rx_DATA = 8'h77;
        step();
        chk("fv_disp_error", {6'b0, Disp_Error}, 7'd1);
        step();
        Rx_FERROR = 1'b0; Rx_VALID = 1'b0;
        step();
        chk("fv_disp_error_held", {6'b0, Disp_Error}, 7'd1);
        chk_digit("fv_d2", 2, S_F);
        chk_digit("fv_d0_dash", 0, S_DASH);

        send_byte(8'h12, 2);
        chk_digit("12_d0", 0, S_2);
        chk_digit("12_d2_blank", 2, S_BLANK);
        send_byte(8'h34, 2);
        chk_digit("34_d3", 3, S_1);
        chk_digit("34_d0", 0, S_4);
        Rx_PERROR = 1'b1;
        step();
        Rx_PERROR = 1'b0;
        chk_digit("pre_rst_d2", 2, S_P);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_an", {3'b0, An}, 7'b0001111);
        chk("mid_rst_seg", Seg, S_BLANK);
        chk("mid_rst_err", {6'b0, Disp_Error}, 7'd0);
        repeat (3) step();
        chk("mid_rst_an_before_tick", {3'b0, An}, 7'b0001111);
        step();
        chk("mid_rst_an_dig0", {3'b0, An}, 7'b0001110);
        chk("mid_rst_seg_dig0", Seg, S_BLANK);
        chk_digit("mid_rst_d3_blank", 3, S_BLANK);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/uart_rx_display_driver.md
Name: uart_rx_display_driver

Overview:
- Downstream consumer of the UART receiver: watches Rx_DATA/Rx_VALID/Rx_PERROR/Rx_FERROR and shows the last two received bytes as four hex digits on a multiplexed, common-anode 7-segment display.
- Latches error indications as a distinct display pattern until the next good byte arrives.
- Owns the digit-refresh counter and the anode scan state machine.

Parameters:
- REFRESH_DIV, 16, Clk cycles each digit is lit (≥2); the refresh tick fires once every REFRESH_DIV cycles.

Ports:
- Clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- Rx_DATA  input  8  received byte, qualified by Rx_VALID
- Rx_VALID  input  1  level; high while Rx_DATA holds a valid byte
- Rx_PERROR  input  1  level; parity error on the last packet
- Rx_FERROR  input  1  level; framing error on the last packet
- An  output  4  anode enables, active-low, An[0] = rightmost digit
- Seg  output  7  segments {a,b,c,d,e,f,g}, active-low
- Disp_Error  output  1  high while the error pattern is displayed

Behaviour:
- Edge detect: register Rx_VALID, Rx_PERROR and Rx_FERROR. An event is a 0→1 transition seen in a cycle. A level held high produces exactly one event.
- Valid event: hi_byte<=lo_byte; lo_byte<=Rx_DATA; byte_cnt<=min(byte_cnt+1,2); err<=0.
  - Exception: if err was 1, hi_byte is not loaded and byte_cnt<=1.
- Error event (PERROR or FERROR rise): err<=1 and err_kind<=FERROR?F:P. Byte registers are untouched.
  - Error and valid events in the same cycle: error wins, the valid byte is dropped.
  - Both error types rising together: F wins.
- Digit content when err=0:
  - D1/D0 = lo_byte hi/lo nibble, shown if byte_cnt≥1, else blank.
  - D3/D2 = hi_byte hi/lo nibble, shown if byte_cnt=2, else blank.
- Digit content when err=1: D3='E', D2='P' or 'F', D1=D0=dash.
- Refresh counter: 0..REFRESH_DIV-1 and wraps. The tick is the cycle in which the counter equals REFRESH_DIV-1.
- Scan FSM: states DIG0→DIG1→DIG2→DIG3→DIG0, advancing on each tick.
  - On each tick, An and Seg are registered for the state being entered.
  - An is one-hot low, e.g. DIG2 → 4'b1011.
- Content changes take effect at the next tick for the digit being lit; there is no glitch within a digit slot.
- Reset (at any time, including mid-scan):
  - counter=0, FSM=DIG3 (the first tick enters DIG0), byte_cnt=0, err=0, bytes=0, edge registers=0.
  - An=4'b1111, Seg=7'b1111111, Disp_Error=0.
  - Disp_Error follows err, registered, same cycle as err.
- Encodings (active-low {a..g}):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - P=0011000, dash=1111110, blank=1111111

Decomposition:
- Shared package: segment constants (SEG_BLANK, SEG_DASH, SEG_E, SEG_P, SEG_F), scan-state encoding DIG0..DIG3 (2-bit), default REFRESH_DIV.
- One sub-module: hex_to_7seg, a combinational 4-bit nibble → 7-bit active-low pattern decoder, instantiated once on the muxed nibble.

Test Plan:
- REFRESH_DIV=4, reset, no input.
  - An stays 1111 until cycle 4, then scans 1110,1101,1011,0111 every 4 cycles.
  - Seg is 1111111 throughout.
- Rx_DATA=8'hA5 with Rx_VALID held high 10 cycles.
  - Single capture.
  - D1 slot shows A (0001000), D0 shows 5 (0100100), D3/D2 blank.
- Then 8'h3C valid.
  - D3..D0 show 'A','5','3','C'.
  - A third byte 8'h0F shifts to '3','C','0','F'.
- Rx_PERROR rises.
  - Disp_Error=1; digits show E,P,dash,dash.
  - Next valid 8'h81 clears the error and shows blank,blank,'8','1'.
- Rx_FERROR and Rx_PERROR rise in the same cycle, then Rx_VALID rises in the same cycle as a new FERROR rise.
  - D2 shows 'F'; the valid byte is dropped; Disp_Error stays 1.
- reset asserted for 1 cycle mid-scan (in DIG2) with two bytes stored.
  - Next cycle: An=1111, Seg=1111111, Disp_Error=0.
  - The first tick lights DIG0 blank.
